chaotic_sbox_builder: RTL and testbench

//  Consumes the chaotic PRNG sample stream and builds a 2^BIT_WIDTH-entry bijective S-box.

---
 rtl/chaos_pkg.sv | 14 +
 rtl/sbox_index_scaler.sv | 22 ++
 rtl/chaotic_sbox_builder.sv | 97 +++++++++
 tb/tb_chaotic_sbox_builder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/chaos_pkg.sv
// Shared defaults and FSM state encoding for the chaotic S-box builder.
package chaos_pkg;

  localparam int unsigned DefaultPrecision = 32;
  localparam int unsigned DefaultBitWidth  = 8;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StInit    = 2'd1,
    StShuffle = 2'd2,
    StDone    = 2'd3
  } sbox_state_e;

endpackage

// File: rtl/sbox_index_scaler.sv
// Maps a BIT_WIDTH-bit random fraction r onto the range 0..i: j = (r * (i+1)) >> BIT_WIDTH.
module sbox_index_scaler #(
  parameter int unsigned BIT_WIDTH = chaos_pkg::DefaultBitWidth
) (
  input  logic [BIT_WIDTH-1:0] r,
  input  logic [BIT_WIDTH-1:0] i,
  output logic [BIT_WIDTH-1:0] j
);

  localparam int unsigned ProdW = 2 * BIT_WIDTH + 1;

  logic [BIT_WIDTH:0] i_plus_one;
  logic [ProdW-1:0]   product;

  // r < 2^BW and i+1 <= 2^BW, so the shifted product always fits in BW bits and is <= i.
  always_comb begin
    i_plus_one = {1'b0, i} + (BIT_WIDTH + 1)'(1);
    product    = ProdW'(r) * ProdW'(i_plus_one);
    j          = BIT_WIDTH'(product >> BIT_WIDTH);
  end

endmodule

// File: rtl/chaotic_sbox_builder.sv
// Builds a bijective 2^BIT_WIDTH-entry S-box by Fisher-Yates shuffling with PRNG samples,
// then serves registered lookups while the table is complete.
module chaotic_sbox_builder
  import chaos_pkg::*;
#(
  parameter int unsigned PRECISION = DefaultPrecision,
  parameter int unsigned BIT_WIDTH = DefaultBitWidth
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tvalid,
  input  logic                 rnd_tvalid,
  input  logic [PRECISION-1:0] rnd_tdata,
  output logic                 rnd_tready,
  input  logic [BIT_WIDTH-1:0] lut_addr,
  output logic [BIT_WIDTH-1:0] lut_data,
  output logic                 busy,
  output logic                 done_sbox
);

  localparam int unsigned N = 2 ** BIT_WIDTH;

  sbox_state_e          state_q, state_d;
  logic [BIT_WIDTH-1:0] idx_q, idx_d;
  logic [BIT_WIDTH-1:0] lut_q;
  logic [BIT_WIDTH-1:0] tbl_q [0:N-1];

  logic                 sample_accept;
  logic [BIT_WIDTH-1:0] r_val;
  logic [BIT_WIDTH-1:0] j_val;

  assign rnd_tready    = (state_q == StShuffle);
  assign busy          = (state_q == StInit) || (state_q == StShuffle);
  assign done_sbox     = (state_q == StDone);
  assign lut_data      = lut_q;
  assign sample_accept = rnd_tready && rnd_tvalid;

  // Top BIT_WIDTH bits of the fixed-point sample act as the random fraction.
  assign r_val = BIT_WIDTH'(rnd_tdata >> (PRECISION - BIT_WIDTH));

  sbox_index_scaler #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_scaler (
    .r(r_val),
    .i(idx_q),
    .j(j_val)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (tvalid) state_d = StInit;
      end
      StInit: begin
        idx_d   = BIT_WIDTH'(N - 1);
        state_d = StShuffle;
      end
      StShuffle: begin
        if (sample_accept) begin
          idx_d = idx_q - BIT_WIDTH'(1);
          if (idx_q == BIT_WIDTH'(1)) state_d = StDone;
        end
      end
      StDone: begin
        if (tvalid) state_d = StInit;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      idx_q   <= BIT_WIDTH'(N - 1);
      lut_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lut_q   <= (state_q == StDone) ? tbl_q[lut_addr] : '0;
    end
  end

  // Table has no reset; INIT refills it before any shuffle step can read it.
  always_ff @(posedge clk) begin
    if (state_q == StInit) begin
      for (int k = 0; k < N; k++) begin
        tbl_q[k] <= BIT_WIDTH'(k);
      end
    end else if (sample_accept) begin
      tbl_q[idx_q] <= tbl_q[j_val];
      tbl_q[j_val] <= tbl_q[idx_q];
    end
  end

endmodule

// File: tb/tb_chaotic_sbox_builder.sv
// Self-checking bench for chaotic_sbox_builder: vector table, software Fisher-Yates model,
// and hand sequences for restart, mid-build reset and rebuild.
module tb_chaotic_sbox_builder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tvalid;
  logic        rnd_tvalid;
  logic [31:0] rnd_tdata;
  logic        rnd_tready;
  logic [7:0]  lut_addr;
  logic [7:0]  lut_data;
  logic        busy;
  logic        done_sbox;

  int checks   = 0;
  int failures = 0;

  logic [31:0] samples [255];
  int          model   [256];
  int          ptr;
  int          hs;
  int          cyc;

  typedef struct {
    int         mode;
    logic [7:0] addr;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  chaotic_sbox_builder #(
    .PRECISION(32),
    .BIT_WIDTH(8)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tvalid    (tvalid),
    .rnd_tvalid(rnd_tvalid),
    .rnd_tdata (rnd_tdata),
    .rnd_tready(rnd_tready),
    .lut_addr  (lut_addr),
    .lut_data  (lut_data),
    .busy      (busy),
    .done_sbox (done_sbox)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // mode 0: 0xFF000000, mode 1: zero, mode 2: random
  task automatic fill_samples(input int mode);
    for (int k = 0; k < 255; k++) begin
      samples[k] = (mode == 0) ? 32'hFF00_0000 : (mode == 1) ? 32'h0 : $urandom;
    end
  endtask

  // Plain Fisher-Yates over the sample list, first sample used at i=255.
  task automatic compute_model();
    int r, j, t;
    for (int k = 0; k < 256; k++) model[k] = k;
    for (int i = 255; i >= 1; i--) begin
      r        = int'(samples[255 - i] / 32'h0100_0000);
      j        = (r * (i + 1)) / 256;
      t        = model[i];
      model[i] = model[j];
      model[j] = t;
    end
  endtask

  task automatic start_build();
    tvalid     = 1'b1;
    rnd_tvalid = 1'b0;
    ptr        = 0;
    hs         = 0;
    @(negedge clk);
    tvalid = 1'b0;
    cyc    = 1;
  endtask

  task automatic finish_build(input int gap_pct, input int tv_at);
    while (!done_sbox && cyc < 2000) begin
      rnd_tvalid = ($urandom_range(99) >= gap_pct);
      rnd_tdata  = (ptr < 255) ? samples[ptr] : $urandom;
      tvalid     = (cyc == tv_at);
      if (rnd_tvalid && rnd_tready) begin
        hs++;
        ptr++;
      end
      @(negedge clk);
      cyc++;
    end
    rnd_tvalid = 1'b0;
    tvalid     = 1'b0;
    check("build_done", done_sbox, 1);
    check("handshakes", hs, 255);
    check("tready_in_done", rnd_tready, 0);
    check("busy_in_done", busy, 0);
  endtask

  task automatic check_table(input string name);
    int seen [256];
    int bad;
    bad = 0;
    for (int k = 0; k < 256; k++) seen[k] = 0;
    for (int a = 0; a < 256; a++) begin
      lut_addr = 8'(a);
      @(negedge clk);
      check(name, lut_data, model[a]);
      seen[lut_data]++;
    end
    for (int k = 0; k < 256; k++) if (seen[k] != 1) bad++;
    check({name, "_perm_bad"}, bad, 0);
  endtask

  initial begin
    int a;

    vecs[0] = '{0, 8'd0,   8'd0};
    vecs[1] = '{0, 8'd1,   8'd1};
    vecs[2] = '{0, 8'd127, 8'd127};
    vecs[3] = '{0, 8'd254, 8'd254};
    vecs[4] = '{0, 8'd255, 8'd255};
    vecs[5] = '{1, 8'd0,   8'd1};
    vecs[6] = '{1, 8'd1,   8'd2};
    vecs[7] = '{1, 8'd100, 8'd101};
    vecs[8] = '{1, 8'd254, 8'd255};
    vecs[9] = '{1, 8'd255, 8'd0};

    reset_n    = 1'b0;
    tvalid     = 1'b0;
    rnd_tvalid = 1'b0;
    rnd_tdata  = '0;
    lut_addr   = '0;
    repeat (3) @(negedge clk);
    check("rst_done", done_sbox, 0);
    check("rst_busy", busy, 0);
    check("rst_tready", rnd_tready, 0);
    check("rst_lut", lut_data, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", busy, 0);

    // Deterministic builds: j==i and j==0
    for (int m = 0; m < 2; m++) begin
      fill_samples(m);
      compute_model();
      start_build();
      finish_build(0, 0);
      check("latency", cyc, 257);
      for (int v = 0; v < 10; v++) begin
        if (vecs[v].mode == m) begin
          lut_addr = vecs[v].addr;
          @(negedge clk);
          check("vec_lut", lut_data, vecs[v].exp);
        end
      end
      check_table(m == 0 ? "ident_tbl" : "rot_tbl");
    end

    // Random samples with random valid gaps
    fill_samples(2);
    compute_model();
    start_build();
    finish_build(30, 0);
    check_table("rand_tbl");

    // Same samples, tvalid pulsed mid-shuffle must be ignored
    start_build();
    finish_build(30, 60);
    check_table("restart_tbl");

    // Reset in the middle of a shuffle
    fill_samples(2);
    start_build();
    repeat (100) begin
      rnd_tvalid = 1'b1;
      rnd_tdata  = $urandom;
      @(negedge clk);
    end
    check("mid_tready", rnd_tready, 1);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_done", done_sbox, 0);
    check("midrst_tready", rnd_tready, 0);
    check("midrst_lut", lut_data, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    reset_n    = 1'b1;
    rnd_tvalid = 1'b0;
    @(negedge clk);
    check("postrst_busy", busy, 0);
    compute_model();
    start_build();
    finish_build(20, 0);
    check_table("postrst_tbl");

    // Rebuild from DONE: done falls next cycle, lut reads 0 after that
    a = (model[0] != 0) ? 0 : 1;
    lut_addr = 8'(a);
    @(negedge clk);
    check("done_lut", lut_data, model[a]);
    fill_samples(2);
    compute_model();
    start_build();
    check("rebuild_done_drop", done_sbox, 0);
    check("rebuild_busy", busy, 1);
    rnd_tvalid = 1'b0;
    @(negedge clk);
    cyc = 2;
    check("rebuild_lut_zero", lut_data, 0);
    finish_build(30, 0);
    check_table("rebuild_tbl");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
